// File: rtl/hazard_ctrl.sv
// Hazard and issue controller for a 5-stage in-order core: tracks EX/MEM/WB destinations,
// resolves load-use / RAW stalls, redirect flushes, memory freezes and operand forwarding.
module hazard_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rd_we,
    input  logic            id_is_load,
    input  logic            ex_redirect,
    input  logic            mem_stall,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_id,
    output logic            issue,
    output logic [1:0]      fwd_rs1,
    output logic [1:0]      fwd_rs2,
    output logic [XLEN-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;

    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_rs1, lu_rs2;
    logic raw_rs1, raw_rs2;
    logic hazard;

    // Stages with rd=0 or we=0 never match, and x0 sources never depend on anything.
    function automatic logic stage_hit(input stage_t s, input logic [4:0] rs);
        return s.valid && s.we && (s.rd != 5'd0) && (rs != 5'd0) && (s.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem, input stage_t wb,
                                           input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'd0;
        if (FWD_EN && (rs != 5'd0)) begin
            // The youngest match masks older ones; an EX load cannot forward yet.
            if (stage_hit(ex, rs)) begin
                sel = ex.is_load ? 2'd0 : 2'd1;
            end else if (stage_hit(mem, rs)) begin
                sel = 2'd2;
            end else if (stage_hit(wb, rs)) begin
                sel = 2'd3;
            end
        end
        return sel;
    endfunction

    always_comb begin
        lu_rs1  = id_valid && stage_hit(ex_q, id_rs1) && ex_q.is_load;
        lu_rs2  = id_valid && stage_hit(ex_q, id_rs2) && ex_q.is_load;
        raw_rs1 = id_valid && (stage_hit(ex_q, id_rs1) || stage_hit(mem_q, id_rs1) ||
                               stage_hit(wb_q, id_rs1));
        raw_rs2 = id_valid && (stage_hit(ex_q, id_rs2) || stage_hit(mem_q, id_rs2) ||
                               stage_hit(wb_q, id_rs2));
        hazard  = FWD_EN ? (lu_rs1 || lu_rs2) : (raw_rs1 || raw_rs2);
    end

    // Priority: memory freeze > redirect flush > data hazard > normal issue.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        issue    = 1'b0;
        if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_redirect) begin
            flush_id = 1'b1;
        end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

    always_comb begin
        fwd_rs1 = fwd_sel(ex_q, mem_q, wb_q, id_rs1);
        fwd_rs2 = fwd_sel(ex_q, mem_q, wb_q, id_rs2);
    end

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = id_rd;
            ex_d.we      = id_rd_we;
            ex_d.is_load = id_is_load;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != {XLEN{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!mem_stall) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

    // The load flag only matters while the producer is in EX.
    logic unused_ld;
    assign unused_ld = mem_q.is_load ^ wb_q.is_load;

endmodule
